// File: rtl/updown_counter_n_pkg.sv
// Shared definitions for the N-bit modulo-M up/down counter: direction
// encoding and the next-count function (also usable by reference models).
package updown_pkg;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam int unsigned MAX_WIDTH = 16;

    // Operands are widened to MAX_WIDTH so one function serves every WIDTH.
    function automatic logic [MAX_WIDTH-1:0] next_count(
        input logic [MAX_WIDTH-1:0] q,
        input logic                 x,
        input int unsigned          modulus,
        input logic                 sat
    );
        logic [MAX_WIDTH-1:0] top;
        top = MAX_WIDTH'(modulus - 1);
        if (x == DIR_UP) begin
            if (q == top) next_count = sat ? top : '0;
            else          next_count = q + MAX_WIDTH'(1);
        end else begin
            if (q == '0)  next_count = sat ? '0 : top;
            else          next_count = q - MAX_WIDTH'(1);
        end
    endfunction

endpackage

// File: rtl/updown_counter_n_if.sv
// Control/status bundle of the up/down counter; master drives the controls.
interface updown_counter_n_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             x;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic             dir_q;

    modport master (output en, x, load, d, input q, tc, wrap, dir_q);
    modport slave  (input en, x, load, d, output q, tc, wrap, dir_q);
endinterface

// File: rtl/updown_counter_n.sv
// N-bit modulo-M up/down counter, state changes on the falling edge of cp.
// Define UPDOWN_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module updown_counter_n
    import updown_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic              cp,
    input  logic              rst,
    updown_counter_n_if.slave bus
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH || MODULUS < 2 || MODULUS > (32'd1 << WIDTH)) begin : g_bad_param
        $error("updown_counter_n: illegal WIDTH=%0d / MODULUS=%0d", WIDTH, MODULUS);
    end

`ifdef UPDOWN_COUNTER_SATURATE_EN
    localparam logic SAT = 1'b1;
`else
    localparam logic SAT = 1'b0;
`endif

    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0]     q_r;
    logic                 wrap_r;
    logic                 dir_r;
    logic                 at_limit;
    logic [WIDTH-1:0]     load_val;
    logic [MAX_WIDTH-1:0] step_wide;
    logic [WIDTH-1:0]     step_val;

    always_comb begin
        at_limit  = (bus.x == DIR_DOWN) ? (q_r == '0) : (q_r == TOP);
        load_val  = (bus.d > TOP) ? TOP : bus.d;
        step_wide = next_count(MAX_WIDTH'(q_r), bus.x, MODULUS, SAT);
        step_val  = step_wide[WIDTH-1:0];
    end

    always_ff @(negedge cp) begin
        if (rst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
            dir_r  <= DIR_UP;
        end else if (bus.load) begin
            q_r    <= load_val;
            wrap_r <= 1'b0;
        end else if (bus.en) begin
            // A step taken at the limit is exactly a wrap unless saturating.
            q_r    <= step_val;
            dir_r  <= bus.x;
            wrap_r <= ~SAT & at_limit;
        end else begin
            wrap_r <= 1'b0;
        end
    end

    assign bus.q     = q_r;
    assign bus.wrap  = wrap_r;
    assign bus.dir_q = dir_r;
    assign bus.tc    = bus.en & at_limit;

endmodule
